// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: decode-side read/issue signals and the two writeback ports.
// The master drives addresses, writes and busy claims; the slave (register file) returns read data.
interface reg_file_mp_if #(
    parameter int address_width = 5,
    parameter int register_size = 32,
    parameter int NUM_READ      = 3
);
    logic [NUM_READ*address_width-1:0] readRegs;
    logic [NUM_READ*register_size-1:0] dataRead;
    logic [NUM_READ-1:0]               busyRead;
    logic                              writeData0;
    logic [address_width-1:0]          writeReg0;
    logic [register_size-1:0]          writeRegData0;
    logic                              writeData1;
    logic [address_width-1:0]          writeReg1;
    logic [register_size-1:0]          writeRegData1;
    logic                              busySet;
    logic [address_width-1:0]          busySetReg;

    modport master (
        output readRegs, writeData0, writeReg0, writeRegData0,
               writeData1, writeReg1, writeRegData1, busySet, busySetReg,
        input  dataRead, busyRead
    );

    modport slave (
        input  readRegs, writeData0, writeReg0, writeRegData0,
               writeData1, writeReg1, writeRegData1, busySet, busySetReg,
        output dataRead, busyRead
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file (NUM_READ sync reads, 2 writes) with a per-register busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data/busy status onto the read ports.
module reg_file_mp #(
    parameter int address_width = 5,
    parameter int register_size = 32,
    parameter int NUM_READ      = 3
) (
    input logic          clk,
    input logic          reset_n,
    reg_file_mp_if.slave bus
);
    localparam int NumRegs = 2 ** address_width;

    logic [register_size-1:0]          registerFile [NumRegs];
    logic [NumRegs-1:0]                busy;
    logic [NumRegs-1:0]                busyNext;
    logic [NUM_READ*register_size-1:0] dataReadNext;
    logic [NUM_READ*register_size-1:0] dataReadQ;
    logic [NUM_READ-1:0]               busyReadNext;
    logic [NUM_READ-1:0]               busyReadQ;
    logic [address_width-1:0]          readAddr;
    logic                              writeEn0;
    logic                              writeEn1;

    assign writeEn0     = bus.writeData0 && (bus.writeReg0 != '0);
    assign writeEn1     = bus.writeData1 && (bus.writeReg1 != '0);
    assign bus.dataRead = dataReadQ;
    assign bus.busyRead = busyReadQ;

    // Port 1 is written last so it wins a same-address collision; x0 is never written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NumRegs; r++) begin
                registerFile[r] <= '0;
            end
        end else begin
            if (writeEn0) begin
                registerFile[bus.writeReg0] <= bus.writeRegData0;
            end
            if (writeEn1) begin
                registerFile[bus.writeReg1] <= bus.writeRegData1;
            end
        end
    end

    // Writes clear busy, then an issue claim overrides the clear for its register
    always_comb begin
        busyNext = busy;
        if (writeEn0) begin
            busyNext[bus.writeReg0] = 1'b0;
        end
        if (writeEn1) begin
            busyNext[bus.writeReg1] = 1'b0;
        end
        if (bus.busySet && (bus.busySetReg != '0)) begin
            busyNext[bus.busySetReg] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    always_comb begin
        dataReadNext = '0;
        busyReadNext = '0;
        readAddr     = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            readAddr = bus.readRegs[k*address_width +: address_width];
            dataReadNext[k*register_size +: register_size] = registerFile[readAddr];
            busyReadNext[k] = busy[readAddr];
`ifdef REG_FILE_BYPASS_EN
            // A matching write means the pending result is landing now, so it is no longer busy
            if (writeEn1 && (bus.writeReg1 == readAddr)) begin
                dataReadNext[k*register_size +: register_size] = bus.writeRegData1;
                busyReadNext[k] = bus.busySet && (bus.busySetReg == readAddr);
            end else if (writeEn0 && (bus.writeReg0 == readAddr)) begin
                dataReadNext[k*register_size +: register_size] = bus.writeRegData0;
                busyReadNext[k] = bus.busySet && (bus.busySetReg == readAddr);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataReadQ <= '0;
            busyReadQ <= '0;
        end else begin
            dataReadQ <= dataReadNext;
            busyReadQ <= busyReadNext;
        end
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the single-cycle core's 2R/1W register file.
- Provides NUM_READ synchronous read ports and two write ports (ALU writeback, load writeback).
- Holds a per-register busy scoreboard so the pipelined core can detect pending writes.
- Sits between decode (reads, busy issue) and writeback (commits); x0 is hardwired to zero.

Parameters:
- address_width, 5, register index width; 2**address_width registers.
- register_size, 32, data width in bits.
- NUM_READ, 3, number of read ports (1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- readRegs  input  NUM_READ*address_width  read addresses; port k occupies bits [k*address_width +: address_width].
- dataRead  output  NUM_READ*register_size  registered read data; port k occupies bits [k*register_size +: register_size].
- busyRead  output  NUM_READ  registered busy flag for each read port's register.
- writeData0  input  1  write enable, port 0.
- writeReg0  input  address_width  write address, port 0.
- writeRegData0  input  register_size  write data, port 0.
- writeData1  input  1  write enable, port 1.
- writeReg1  input  address_width  write address, port 1.
- writeRegData1  input  register_size  write data, port 1.
- busySet  input  1  mark busySetReg as pending (instruction issued).
- busySetReg  input  address_width  register being claimed.

Behaviour:
- Reset (asynchronous, reset_n low): all registers = 0, all busy bits = 0, dataRead = 0, busyRead = 0. Effect is immediate, not clock-gated. Reset asserted mid-operation discards any in-flight write on that edge.
- Read latency is 1 cycle. At posedge, dataRead[k] <= registerFile[readRegs[k]] and busyRead[k] <= busy[readRegs[k]], sampling pre-edge state (read-before-write) unless the bypass macro is defined.
- Write: at posedge, if writeDataN is set and writeRegN != 0, then registerFile[writeRegN] <= writeRegDataN.
- Write collision: both ports enabled to the same nonzero address means port 1 wins.
- x0: writes are dropped, reads always return 0, busy[0] is never set, and busyRead for address 0 is always 0.
- Scoreboard, per register r != 0, at each edge:
  - set (busySet && busySetReg == r) has priority over clear; result is busy[r] = 1.
  - otherwise clear (any enabled write port to r) gives busy[r] = 0.
  - otherwise busy[r] holds.
- Set and clear of different registers in the same cycle are independent.
- No other state, no stalls generated internally; consumers interpret busyRead.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined (write-through forwarding), per read port k, when readRegs[k] matches an enabled write address != 0:
  - dataRead[k] captures the incoming write data, with port 1 taking priority over port 0.
  - busyRead[k] captures 0, unless busySet targets the same register that cycle, in which case it captures 1.
- Not defined: strict read-before-write as described above; the consumer sees the new value one cycle later.
- Storage and scoreboard updates are identical in both builds.

Test Plan:
- Reset, then read x1..x3 on three ports -> dataRead = 0 and busyRead = 0 for all ports; assert reset_n mid-run after writing x5=0xDEADBEEF -> next read of x5 returns 0.
- Write x7=0x12345678 via port 0, read x7 the next cycle -> 0x12345678 one cycle later; write x0=0xFFFFFFFF -> reading x0 returns 0.
- Same cycle, port 0 writes x9=0xAAAA0000 and port 1 writes x9=0x0000BBBB -> subsequent read of x9 returns 0x0000BBBB.
- Read x4 (holds 0x11) in the same cycle as a write of x4=0x22:
  - without REG_FILE_BYPASS_EN -> dataRead = 0x11, and 0x22 on the next read;
  - with the macro -> dataRead = 0x22 immediately.
- busySet x10, then read x10 -> busyRead = 1; write x10 via port 1 -> next read busyRead = 0; busySet x10 plus write x10 in the same cycle -> busy stays 1; busySet x0 -> busyRead for x0 stays 0.
- Four read ports (NUM_READ = 4) reading x1, x2, x1, x31 after distinct writes -> each lane returns its own register value, and lane 0 equals lane 2.
